// File: rtl/mem_port_arbiter_pkg.sv
// Message codes and FSM encoding shared by the main-memory port arbiter and its picker.
package mem_port_arbiter_pkg;

  localparam logic [2:0] NO_REQ    = 3'd0;
  localparam logic [2:0] R_REQ     = 3'd1;
  localparam logic [2:0] WB_REQ    = 3'd2;
  localparam logic [2:0] MEM_SENT  = 3'd3;
  localparam logic [2:0] MEM_READY = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational one-hot picker: round-robin from last_served+1, or fixed priority (highest index wins).
// Zero latency; no state, no backpressure.
module rr_select #(
  parameter int NUM_PORTS     = 2,
  parameter int PRIORITY_MODE = 0,
  parameter int PTR_W         = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     last_served,
  output logic [NUM_PORTS-1:0] winner
);

  always_comb begin
    winner = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((req & (NUM_PORTS'(1) << i)) != '0) winner = NUM_PORTS'(1) << i;
      end
    end else begin
      // Walk from farthest to nearest so the port right after last_served overrides.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        if ((req & (NUM_PORTS'(1) << ((int'(last_served) + k) % NUM_PORTS))) != '0)
          winner = NUM_PORTS'(1) << ((int'(last_served) + k) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between the L2 interface (port 0) and secure bypass (port 1).
// Grant 1 cycle after request; combinational forward/response paths; losers held off until release.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int MSG_BITS       = 3,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]      req_msg,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]      rsp_msg,
  output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] rsp_address,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rsp_data,
  output logic [MSG_BITS-1:0]                arb2mm_msg,
  output logic [ADDRESS_WIDTH-1:0]           arb2mm_address,
  output logic [DATA_WIDTH-1:0]              arb2mm_data,
  input  logic [MSG_BITS-1:0]                mm2arb_msg,
  input  logic [ADDRESS_WIDTH-1:0]           mm2arb_address,
  input  logic [DATA_WIDTH-1:0]              mm2arb_data,
  output logic [NUM_PORTS-1:0]               grant,
  output logic                               timeout_err
);

  localparam int                  PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int                  CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [MSG_BITS-1:0] NO_MSG  = MSG_BITS'(NO_REQ);

  arb_state_t           state, state_next;
  logic [NUM_PORTS-1:0] req_vld, winner, grant_next;
  logic [CNT_W-1:0]     count, count_next, count_inc;
  logic [PTR_W-1:0]     last_served, last_next, served_idx;
  logic                 err_next, end_cond;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      req_vld[i] = (req_msg[i*MSG_BITS +: MSG_BITS] != NO_MSG);
  end

  rr_select #(
    .NUM_PORTS    (NUM_PORTS),
    .PRIORITY_MODE(PRIORITY_MODE),
    .PTR_W        (PTR_W)
  ) u_rr_select (
    .req        (req_vld),
    .last_served(last_served),
    .winner     (winner)
  );

  // Grant is only non-zero in GRANT, so it alone steers both directions.
  always_comb begin
    arb2mm_msg     = NO_MSG;
    arb2mm_address = '0;
    arb2mm_data    = '0;
    rsp_msg        = {NUM_PORTS{NO_MSG}};
    rsp_address    = '0;
    rsp_data       = '0;
    served_idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state == GRANT && grant[i]) begin
        arb2mm_msg                                 = req_msg[i*MSG_BITS +: MSG_BITS];
        arb2mm_address                             = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        arb2mm_data                                = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        rsp_msg[i*MSG_BITS +: MSG_BITS]            = mm2arb_msg;
        rsp_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = mm2arb_address;
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH]       = mm2arb_data;
        served_idx                                 = PTR_W'(i);
      end
    end
    end_cond  = (arb2mm_msg == NO_MSG) && (mm2arb_msg == NO_MSG);
    count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    count_next = count;
    err_next   = timeout_err;
    last_next  = last_served;
    case (state)
      IDLE: begin
        if (req_vld != '0) begin
          state_next = GRANT;
          grant_next = winner;
          count_next = '0;
        end
      end
      GRANT: begin
        count_next = count_inc;
        if (count_inc == CNT_MAX || end_cond) begin
          state_next = RELEASE;
          grant_next = '0;
          last_next  = served_idx;
          if (count_inc == CNT_MAX) err_next = 1'b1;
        end
      end
      RELEASE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      count       <= '0;
      timeout_err <= 1'b0;
      last_served <= PTR_W'(NUM_PORTS - 1);
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      count       <= count_next;
      timeout_err <= err_next;
      last_served <= last_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin/timeout instance (dut_a) and fixed-priority instance (dut_b) on shared stimulus.
module tb_mem_port_arbiter;

  localparam logic [2:0] NO = 3'd0, RQ = 3'd1, WB = 3'd2, MS = 3'd3, MR = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  req_msg;
  logic [63:0] req_address = {32'h0000_0200, 32'h0000_0100};
  logic [63:0] req_data    = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
  logic [2:0]  mm_msg;
  logic [31:0] mm_address = 32'h0000_0300;
  logic [31:0] mm_data;

  logic [5:0]  a_rsp_msg, b_rsp_msg;
  logic [63:0] a_rsp_address, b_rsp_address, a_rsp_data, b_rsp_data;
  logic [2:0]  a_arb_msg, b_arb_msg;
  logic [31:0] a_arb_address, b_arb_address, a_arb_data, b_arb_data;
  logic [1:0]  a_grant, b_grant;
  logic        a_err, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.NUM_PORTS(2), .MSG_BITS(3), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
                     .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clock(clock), .reset(reset), .req_msg(req_msg), .req_address(req_address), .req_data(req_data),
    .rsp_msg(a_rsp_msg), .rsp_address(a_rsp_address), .rsp_data(a_rsp_data),
    .arb2mm_msg(a_arb_msg), .arb2mm_address(a_arb_address), .arb2mm_data(a_arb_data),
    .mm2arb_msg(mm_msg), .mm2arb_address(mm_address), .mm2arb_data(mm_data),
    .grant(a_grant), .timeout_err(a_err));

  mem_port_arbiter #(.NUM_PORTS(2), .MSG_BITS(3), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
                     .PRIORITY_MODE(1), .TIMEOUT_CYCLES(1023)) dut_b (
    .clock(clock), .reset(reset), .req_msg(req_msg), .req_address(req_address), .req_data(req_data),
    .rsp_msg(b_rsp_msg), .rsp_address(b_rsp_address), .rsp_data(b_rsp_data),
    .arb2mm_msg(b_arb_msg), .arb2mm_address(b_arb_address), .arb2mm_data(b_arb_data),
    .mm2arb_msg(mm_msg), .mm2arb_address(mm_address), .mm2arb_data(mm_data),
    .grant(b_grant), .timeout_err(b_err));

  typedef struct {
    logic [2:0]  m0, m1, mm;
    logic [31:0] md;
    logic [1:0]  eg;
    logic [2:0]  eam;
    logic [31:0] eaa, ead;
    logic [5:0]  ers;
    logic [31:0] erd0, erd1;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [2:0] m0, m1, mm, input logic [31:0] md,
                              input logic [1:0] eg, input logic [2:0] eam,
                              input logic [31:0] eaa, ead, input logic [5:0] ers,
                              input logic [31:0] erd0, erd1);
    vec_t v;
    v.m0 = m0; v.m1 = m1; v.mm = mm; v.md = md; v.eg = eg; v.eam = eam;
    v.eaa = eaa; v.ead = ead; v.ers = ers; v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [2:0] m0, m1, mm, input logic [31:0] md);
    reset   = r;
    req_msg = {m1, m0};
    mm_msg  = mm;
    mm_data = md;
  endtask

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    // Port-0 read with response, port-1 write held off then served, then an immediate-end grant.
    tbl[0]  = mk(RQ, NO, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);
    tbl[1]  = mk(RQ, NO, MS, 32'hDEADBEEF,  2'b01, RQ, 32'h100, 32'hA0A0A0A0,  6'h03, 32'hDEADBEEF,  32'h0);
    tbl[2]  = mk(NO, NO, NO, 32'h0,         2'b01, NO, 32'h100, 32'hA0A0A0A0,  6'h00, 32'h0,         32'h0);
    tbl[3]  = mk(RQ, WB, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);
    tbl[4]  = mk(RQ, WB, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);
    tbl[5]  = mk(RQ, WB, MR, 32'hCAFE0001,  2'b10, WB, 32'h200, 32'hB1B1B1B1,  6'h20, 32'h0,         32'hCAFE0001);
    tbl[6]  = mk(RQ, NO, NO, 32'h0,         2'b10, NO, 32'h200, 32'hB1B1B1B1,  6'h00, 32'h0,         32'h0);
    tbl[7]  = mk(RQ, NO, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);
    tbl[8]  = mk(RQ, NO, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);
    tbl[9]  = mk(NO, NO, NO, 32'h0,         2'b01, NO, 32'h100, 32'hA0A0A0A0,  6'h00, 32'h0,         32'h0);
    tbl[10] = mk(NO, NO, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);
    tbl[11] = mk(NO, NO, NO, 32'h0,         2'b00, NO, 32'h0,   32'h0,         6'h00, 32'h0,         32'h0);

    drive(1'b1, NO, NO, NO, 32'h0);
    step; step;
    chk("reset grant", {62'd0, a_grant}, 64'd0);
    chk("reset arb_msg", {61'd0, a_arb_msg}, 64'd0);
    chk("reset rsp_msg", {58'd0, a_rsp_msg}, 64'd0);
    chk("reset err", {63'd0, a_err}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].m0, tbl[i].m1, tbl[i].mm, tbl[i].md);
      #1;
      chk($sformatf("vec%0d grant", i),    {62'd0, a_grant},       {62'd0, tbl[i].eg});
      chk($sformatf("vec%0d arb_msg", i),  {61'd0, a_arb_msg},     {61'd0, tbl[i].eam});
      chk($sformatf("vec%0d arb_addr", i), {32'd0, a_arb_address}, {32'd0, tbl[i].eaa});
      chk($sformatf("vec%0d arb_data", i), {32'd0, a_arb_data},    {32'd0, tbl[i].ead});
      chk($sformatf("vec%0d rsp_msg", i),  {58'd0, a_rsp_msg},     {58'd0, tbl[i].ers});
      chk($sformatf("vec%0d rsp_data", i), a_rsp_data,             {tbl[i].erd1, tbl[i].erd0});
      step;
    end

    // Round-robin: tie after reset goes to port 0, then strict alternation with two dead cycles.
    drive(1'b1, NO, NO, NO, 32'h0);
    step;
    drive(1'b0, RQ, WB, NO, 32'h0);
    #1 chk("rr idle grant", {62'd0, a_grant}, 64'd0);
    step;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] eg;
      int p;
      p  = t % 2;
      eg = (p == 0) ? 2'b01 : 2'b10;
      drive(1'b0, RQ, WB, MS, 32'h1000 + t);
      #1;
      chk($sformatf("rr%0d grant", t), {62'd0, a_grant}, {62'd0, eg});
      chk($sformatf("rr%0d rsp_msg", t), {58'd0, a_rsp_msg}, {58'd0, 6'(MS) << (3 * p)});
      chk($sformatf("rr%0d rsp_data", t), a_rsp_data, {32'd0, 32'h1000 + t} << (32 * p));
      step;
      drive(1'b0, (p == 0) ? NO : RQ, (p == 1) ? NO : WB, NO, 32'h0);
      #1 chk($sformatf("rr%0d end grant", t), {62'd0, a_grant}, {62'd0, eg});
      step;
      drive(1'b0, RQ, WB, NO, 32'h0);
      #1 chk($sformatf("rr%0d release", t), {62'd0, a_grant}, 64'd0);
      step;
      #1 chk($sformatf("rr%0d idle", t), {62'd0, a_grant}, 64'd0);
      step;
    end

    // Fixed priority: port 1 always wins, port 0 never sees a response.
    drive(1'b1, NO, NO, NO, 32'h0);
    step;
    drive(1'b0, RQ, WB, NO, 32'h0);
    step;
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, RQ, WB, MS, 32'h2000 + t);
      #1;
      chk($sformatf("fp%0d grant", t), {62'd0, b_grant}, 64'd2);
      chk($sformatf("fp%0d rsp_msg", t), {58'd0, b_rsp_msg}, {58'd0, 6'h18});
      step;
      drive(1'b0, RQ, NO, NO, 32'h0);
      #1 chk($sformatf("fp%0d end grant", t), {62'd0, b_grant}, 64'd2);
      step;
      drive(1'b0, RQ, WB, NO, 32'h0);
      #1 chk($sformatf("fp%0d release", t), {62'd0, b_grant}, 64'd0);
      step;
      #1 chk($sformatf("fp%0d idle", t), {62'd0, b_grant}, 64'd0);
      step;
    end

    // Watchdog: exactly 8 GRANT cycles, then forced release with a sticky flag.
    drive(1'b1, NO, NO, NO, 32'h0);
    step;
    drive(1'b0, RQ, NO, NO, 32'h0);
    #1 chk("wd idle grant", {62'd0, a_grant}, 64'd0);
    step;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("wd%0d grant", k), {62'd0, a_grant}, 64'd1);
      chk($sformatf("wd%0d err", k), {63'd0, a_err}, 64'd0);
      step;
    end
    drive(1'b0, NO, NO, NO, 32'h0);
    #1;
    chk("wd release grant", {62'd0, a_grant}, 64'd0);
    chk("wd release arb_msg", {61'd0, a_arb_msg}, 64'd0);
    chk("wd release err", {63'd0, a_err}, 64'd1);
    step;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("wd sticky%0d", k), {63'd0, a_err}, 64'd1);
      step;
    end

    // Reset mid-grant: port 1 holds the grant (port 0 was last served), reset clears everything.
    drive(1'b0, RQ, WB, NO, 32'h0);
    #1 chk("rst idle grant", {62'd0, a_grant}, 64'd0);
    step;
    #1;
    chk("rst pre grant", {62'd0, a_grant}, 64'd2);
    chk("rst pre err", {63'd0, a_err}, 64'd1);
    drive(1'b1, RQ, WB, NO, 32'h0);
    step;
    drive(1'b0, RQ, WB, NO, 32'h0);
    #1;
    chk("rst post grant", {62'd0, a_grant}, 64'd0);
    chk("rst post arb_msg", {61'd0, a_arb_msg}, 64'd0);
    chk("rst post err", {63'd0, a_err}, 64'd0);
    step;
    #1;
    chk("rst regrant", {62'd0, a_grant}, 64'd1);
    chk("rst regrant arb_msg", {61'd0, a_arb_msg}, {61'd0, RQ});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory port between the L2 main-memory interface (port 0) and the secure L2 bypass (port 1). Grants one requester at a time for a whole transaction, forwards its msg/address/data to memory and routes memory responses back only to the granted port. Round-robin or fixed-priority arbitration, with a transaction watchdog. Sits between the memory hierarchy's two memory-facing ports and the external main memory.

## Interface
- `NUM_PORTS`, 2: requester count; port 0 is the L2 interface, port 1 is the bypass.
- `MSG_BITS`, 3: message code width.
- `ADDRESS_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data word width.
- `PRIORITY_MODE`, 0: 0 selects round-robin; 1 selects fixed priority, highest index wins.
- `TIMEOUT_CYCLES`, 1023: maximum cycles in GRANT before forced release.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `req_msg`  in  NUM_PORTS*MSG_BITS  requester messages, packed with port 0 in the LSBs.
- `req_address`  in  NUM_PORTS*ADDRESS_WIDTH  requester addresses.
- `req_data`  in  NUM_PORTS*DATA_WIDTH  requester write data.
- `rsp_msg`  out  NUM_PORTS*MSG_BITS  responses to requesters.
- `rsp_address`  out  NUM_PORTS*ADDRESS_WIDTH  response addresses.
- `rsp_data`  out  NUM_PORTS*DATA_WIDTH  response data.
- `arb2mm_msg`  out  MSG_BITS  message to main memory.
- `arb2mm_address`  out  ADDRESS_WIDTH  address to main memory.
- `arb2mm_data`  out  DATA_WIDTH  data to main memory.
- `mm2arb_msg`  in  MSG_BITS  main-memory response message.
- `mm2arb_address`  in  ADDRESS_WIDTH  main-memory response address.
- `mm2arb_data`  in  DATA_WIDTH  main-memory response data.
- `grant`  out  NUM_PORTS  one-hot grant; all zero outside GRANT.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- A port is requesting when its `req_msg` != NO_REQ. Message codes come from the shared params.
- **IDLE:**
  - All memory outputs are 0 and all `rsp_msg` are NO_REQ.
  - If any port is requesting, select a winner, register it in `grant`, clear the watchdog counter, and go to GRANT.
- **GRANT:**
  - `arb2mm_*` = the granted port's `req_*` (combinational mux on registered grant).
  - The granted port's `rsp_*` = `mm2arb_*`. Non-granted ports see `rsp_msg` = NO_REQ with address and data 0.
  - Go to RELEASE when the granted `req_msg` == NO_REQ and `mm2arb_msg` == NO_REQ in the same cycle.
  - Go to RELEASE when the watchdog reaches `TIMEOUT_CYCLES`; this also sets `timeout_err`.
- **RELEASE:**
  - One turnaround cycle: `grant` = 0 and memory outputs are driven NO_REQ/0.
  - Update the round-robin pointer to the port just served, then go to IDLE.
- **Round-robin:** search starts at (last_served+1) mod NUM_PORTS. After reset last_served = NUM_PORTS-1, so port 0 wins the first tie.
- **Fixed priority:** highest requesting index wins; the pointer is ignored.
- **Requests during GRANT:** held off with no response; the requester keeps its msg asserted.
- **Reset:** state = IDLE, `grant` = 0, all outputs 0/NO_REQ, counter = 0, `timeout_err` = 0, last_served = NUM_PORTS-1. Reset mid-transaction abandons the transaction with no release cycle.
- `timeout_err` clears only on reset.

## Timing
- Request seen in IDLE at cycle N produces `grant` and forwarding at N+1. Minimum grant latency is 1 cycle.
- Response path is combinational, zero-cycle, memory to requester.
- End condition seen at cycle M: RELEASE at M+1, IDLE at M+2. The earliest next grant is M+3.
- Back-to-back transactions therefore carry 2 dead cycles.
- Watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits. It increments every GRANT cycle and saturates; it never wraps.
- A request and the end condition in the same cycle do not regrant early; the request is handled via RELEASE and then IDLE.

## Structure
- Shared params include holds the message codes (NO_REQ, R_REQ, WB_REQ, MEM_SENT, MEM_READY) and the state encoding localparams (IDLE, GRANT, RELEASE).
- One natural sub-module, `rr_select`: combinational NUM_PORTS-wide round-robin/fixed-priority picker taking the request vector and pointer, returning a one-hot winner.
- Everything else (FSM, watchdog, muxes) lives in `mem_port_arbiter`.

## Test plan
1. Port 0 R_REQ to 0x100; memory answers MEM_SENT with 0xDEADBEEF -> `grant` = 01 one cycle later; `rsp_data[31:0]` = 0xDEADBEEF; port 1 `rsp_msg` = NO_REQ.
2. Both ports request in the same cycle after reset (round-robin) -> port 0 granted first; port 1 granted 3 cycles after port 0's end condition.
3. Both ports request continuously for 4 transactions -> grants alternate 01, 10, 01, 10 with 2 idle cycles between.
4. PRIORITY_MODE=1, both ports requesting continuously -> port 1 always granted; port 0 never granted.
5. TIMEOUT_CYCLES=8; granted port never drops its msg -> forced RELEASE after 8 GRANT cycles; `timeout_err` = 1 and stays 1 until reset.
6. `reset` asserted mid-GRANT -> next cycle `grant` = 0, `arb2mm_msg` = NO_REQ, `timeout_err` = 0; a following simultaneous request grants port 0.
